// File: rtl/aclk_keypad_scan_if.sv
// aclk_keypad_scan_if: keypad matrix pins and debounced key outputs of the scanner
interface aclk_keypad_scan_if;
  logic [2:0] col_sense;
  logic [3:0] row_drive;
  logic [3:0] key;
  logic       time_button;
  logic       alarm_button;
  logic       key_strobe;
  modport master(input col_sense, output row_drive, key, time_button, alarm_button, key_strobe);
  modport slave(output col_sense, input row_drive, key, time_button, alarm_button, key_strobe);
endinterface

// File: rtl/aclk_keypad_scan.sv
// aclk_keypad_scan: 4x3 keypad row scanner with whole-scan debounce and digit strobe
module aclk_keypad_scan #(
  parameter logic [7:0] SCAN_DIV       = 8'd200,
  parameter logic [3:0] DEBOUNCE_SCANS = 4'd4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  aclk_keypad_scan_if.master  kp
);
  typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} state_t;
  localparam logic [3:0] NONE = 4'd10;
  localparam logic [3:0] STAR = 4'd11;
  localparam logic [3:0] HASH = 4'd12;
  state_t      r_state, w_next;
  logic [2:0]  r_sync1, r_sync2;
  logic [7:0]  r_div;
  logic        w_tick, w_done;
  logic [11:0] r_img, w_img;
  logic [3:0]  w_n, w_idx, w_raw, w_cnt, w_acc, w_row;
  logic [3:0]  r_prev, r_cnt, r_acc, r_row, r_key;
  logic        r_tb, r_ab, r_strobe;
  always_comb begin
    w_tick = r_div == SCAN_DIV - 8'd1;
    w_next = w_tick ? state_t'(r_state + 2'd1) : r_state;
    w_row  = w_next == ROW0 ? 4'b1110 : w_next == ROW1 ? 4'b1101 : w_next == ROW2 ? 4'b1011 : 4'b0111;
    w_done = w_tick && r_state == ROW3;
    // Image bit is the column level (1 = up); row3 is taken live on the completing tick
    w_img  = {r_sync2, r_img[8:0]};
    w_n    = 4'd0;
    w_idx  = 4'd0;
    for (int i = 0; i < 12; i++)
      if (!w_img[i]) begin
        w_n   = w_n + 4'd1;
        w_idx = i[3:0];
      end
    w_raw = w_n != 4'd1 ? NONE : w_idx < 4'd9 ? w_idx + 4'd1 : w_idx == 4'd9 ? STAR : w_idx == 4'd10 ? 4'd0 : HASH;
    w_cnt = w_raw != r_prev ? 4'd1 : r_cnt >= DEBOUNCE_SCANS ? DEBOUNCE_SCANS : r_cnt + 4'd1;
    w_acc = (w_done && w_cnt == DEBOUNCE_SCANS) ? w_raw : r_acc;
  end
  always_ff @(posedge i_clock)
    if (i_reset) r_state <= ROW0;
    else r_state <= w_next;
  always_ff @(posedge i_clock)
    if (i_reset) begin
      r_sync1  <= 3'b111;
      r_sync2  <= 3'b111;
      r_div    <= 8'd0;
      r_row    <= 4'b1110;
      r_img    <= 12'hfff;
      r_prev   <= NONE;
      r_cnt    <= 4'd0;
      r_acc    <= NONE;
      r_key    <= NONE;
      r_tb     <= 1'b0;
      r_ab     <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_sync1  <= kp.col_sense;
      r_sync2  <= r_sync1;
      r_div    <= w_tick ? 8'd0 : r_div + 8'd1;
      r_row    <= w_row;
      if (w_tick) r_img[{2'b00, r_state} * 4'd3 +: 3] <= r_sync2;
      if (w_done) begin
        r_prev <= w_raw;
        r_cnt  <= w_cnt;
      end
      r_acc    <= w_acc;
      r_key    <= w_acc <= 4'd9 ? w_acc : NONE;
      r_tb     <= w_acc == STAR;
      r_ab     <= w_acc == HASH;
      r_strobe <= w_acc != r_acc && w_acc <= 4'd9;
    end
  assign kp.row_drive    = r_row;
  assign kp.key          = r_key;
  assign kp.time_button  = r_tb;
  assign kp.alarm_button = r_ab;
  assign kp.key_strobe   = r_strobe;
endmodule
